noc_mux: RTL and testbench
==========================

NOC_MUX -- requirements
Module: noc_mux

Interface
REQ-001 SHALL have parameters: N_RN, default 4, number of request-node ports; DEPTH, default 4, request FIFO entries per port; SN_CREDITS, default 2, initial credits toward the SN.
REQ-002 SHALL use one clock and a reset that is asynchronous and active-high; ports are clk and reset.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- rx_req[N_RN]  in  ReqType  per-port request from an RN.
- v_rx_req[N_RN]  in  1  per-port request valid.
- pre_rx_req[N_RN]  out  1  credit return to the RN; one pulse per freed FIFO entry.
- tx_req  out  ReqType  request to the SN.
- v_tx_req  out  1  request valid toward the SN.
- pre_tx_req  in  1  credit return from the SN.
- rx_data  in  DataType  response from the SN.
- v_rx_data  in  1  response valid.
- pre_rx_data  out  1  credit return to the SN for the data channel.
- tx_data[N_RN]  out  DataType  response routed to an RN.
- v_tx_data[N_RN]  out  1  per-port response valid.
- err  out  1  sticky protocol-error flag.

Function
REQ-004 SHALL write rx_req[i] into FIFO i on every cycle where v_rx_req[i]=1, with no ready signal; RN-side flow control is by credits only, and each RN starts with DEPTH credits.
REQ-005 SHALL drop a write to a full FIFO i and set err; FIFO contents SHALL remain unchanged.
REQ-006 SHALL hold SN credit counter cnt, range 0..SN_CREDITS.
REQ-007 SHALL issue a request when cnt>0 and at least one FIFO is non-empty.
REQ-008 On issue, the grant SHALL go to the first non-empty port at or after rr_ptr, in round-robin order modulo N_RN.
REQ-009 On a grant to port g: pop FIFO g; register tx_req with its src field overwritten by g; set v_tx_req=1 for exactly that cycle; advance rr_ptr to (g+1) mod N_RN.
REQ-010 SHALL drive v_tx_req=0 on every cycle with no grant; tx_req SHALL hold its last value.
REQ-011 SHALL assert pre_rx_req[g] for one cycle, in the same cycle v_tx_req is asserted for port g.
REQ-012 Latency: a request written at edge t into an empty FIFO, with cnt>0 and no competing ports, SHALL appear on tx_req after edge t+1.
REQ-013 cnt SHALL decrement on grant and increment on pre_tx_req; when both occur in the same cycle, cnt SHALL be unchanged.
REQ-014 When pre_tx_req=1 with cnt=SN_CREDITS and no grant, cnt SHALL be unchanged and err SHALL be set.
REQ-015 On v_rx_data=1 with rx_data.dst<N_RN, the next edge SHALL register tx_data[dst]=rx_data and set v_tx_data[dst]=1 for one cycle; all other v_tx_data SHALL be 0.
REQ-016 On v_rx_data=1 with rx_data.dst>=N_RN, the beat SHALL be dropped and err set.
REQ-017 pre_rx_data SHALL pulse one cycle after every accepted or dropped data beat; RNs always sink data.
REQ-018 The request and data paths SHALL be independent and may be active in the same cycle.
REQ-019 err SHALL stay at 1 until reset.

Reset
REQ-020 While reset=1: all FIFOs empty, cnt=SN_CREDITS, rr_ptr=0, err=0; all v_*, pre_* outputs, tx_req and tx_data SHALL be 0.
REQ-021 Reset asserted mid-transfer SHALL discard all queued requests and in-flight data; no credit pulses SHALL be emitted for them.
REQ-022 Deassertion of reset SHALL emit no credit pulses.

Structure
REQ-023 node_package SHALL define NODE_ID_W, ReqType {src, addr, op} and DataType {dst, payload}; src and dst are NODE_ID_W bits wide, and NODE_ID_W >= $clog2(N_RN).
REQ-024 The per-port queue SHALL be the sub-module noc_fifo (params WIDTH, DEPTH; push, pop, full, empty), instantiated N_RN times; pointers wrap modulo DEPTH.
REQ-025 The arbiter and credit counter SHALL be inside noc_mux.

Verification
REQ-026 Reset, then a single request on port 2 (addr=0x10) -> tx_req.src=2, addr=0x10 one cycle later; pre_rx_req[2] pulses with v_tx_req; cnt=1.
REQ-027 All 4 ports hold 2 requests each, SN returns a credit every cycle -> grant order 0,1,2,3,0,1,2,3 with no gaps after the first.
REQ-028 No SN credit returns, 5 requests queued -> exactly SN_CREDITS=2 issues, then v_tx_req stays 0; a single pre_tx_req pulse -> exactly one more issue.
REQ-029 5 writes to port 1 with no drain -> the 5th write is dropped and err=1; the first 4 later drain in order.
REQ-030 rx_data.dst=3 -> v_tx_data[3] is 1 next cycle, then pre_rx_data pulses; dst=7 -> beat dropped, err=1.
REQ-031 Reset asserted with 3 entries queued -> after release, no v_tx_req and no pre_* pulses; cnt=2.

Source files
------------

// File: rtl/node_package.sv
// rtl/node_package.sv - shared node identifiers and request/response beat formats
package node_package;

    localparam int NODE_ID_W = 3;
    localparam int ADDR_W    = 16;
    localparam int OP_W      = 2;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic [NODE_ID_W-1:0] src;
        logic [ADDR_W-1:0]    addr;
        logic [OP_W-1:0]      op;
    } ReqType;

    typedef struct packed {
        logic [NODE_ID_W-1:0] dst;
        logic [PAYLOAD_W-1:0] payload;
    } DataType;

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - per-port request queue; pushes to a full queue are ignored
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Explicit wrap so non-power-of-two depths stay in range
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/noc_mux.sv
// rtl/noc_mux.sv - credit-based N:1 request mux toward an SN with 1:N response demux
module noc_mux
    import node_package::*;
#(
    parameter int N_RN       = 4,
    parameter int DEPTH      = 4,
    parameter int SN_CREDITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  ReqType          rx_req [N_RN],
    input  logic [N_RN-1:0] v_rx_req,
    output logic [N_RN-1:0] pre_rx_req,
    output ReqType          tx_req,
    output logic            v_tx_req,
    input  logic            pre_tx_req,
    input  DataType         rx_data,
    input  logic            v_rx_data,
    output logic            pre_rx_data,
    output DataType         tx_data [N_RN],
    output logic [N_RN-1:0] v_tx_data,
    output logic            err
);

    localparam int PTR_W = (N_RN > 1) ? $clog2(N_RN) : 1;
    localparam int CNT_W = $clog2(SN_CREDITS + 1);

    logic [N_RN-1:0]  fifo_full;
    logic [N_RN-1:0]  fifo_empty;
    logic [N_RN-1:0]  fifo_pop;
    ReqType           fifo_rdata [N_RN];
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_valid;
    ReqType           gnt_req;
    logic [CNT_W-1:0] cnt;
    logic             push_overflow;
    logic             credit_overflow;
    logic             bad_dst;

    for (genvar i = 0; i < N_RN; i++) begin : g_port
        noc_fifo #(
            .WIDTH($bits(ReqType)),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (v_rx_req[i]),
            .wdata (rx_req[i]),
            .pop   (fifo_pop[i]),
            .rdata (fifo_rdata[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Round-robin scan starting at rr_ptr; only grants while SN credit remains
    always_comb begin
        logic [PTR_W-1:0] idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < N_RN; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N_RN);
            if (!gnt_valid && !fifo_empty[idx] && cnt != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (gnt_valid) fifo_pop[gnt_idx] = 1'b1;
        gnt_req     = fifo_rdata[gnt_idx];
        gnt_req.src = NODE_ID_W'(gnt_idx);
    end

    assign push_overflow   = |(v_rx_req & fifo_full);
    assign credit_overflow = pre_tx_req && !gnt_valid && (cnt == CNT_W'(SN_CREDITS));
    assign bad_dst         = v_rx_data && (int'(rx_data.dst) >= N_RN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            cnt        <= CNT_W'(SN_CREDITS);
            tx_req     <= '0;
            v_tx_req   <= 1'b0;
            pre_rx_req <= '0;
        end else begin
            v_tx_req   <= gnt_valid;
            pre_rx_req <= fifo_pop;
            if (gnt_valid) begin
                tx_req <= gnt_req;
                rr_ptr <= (gnt_idx == PTR_W'(N_RN - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            if (gnt_valid && !pre_tx_req) begin
                cnt <= cnt - CNT_W'(1);
            end else if (!gnt_valid && pre_tx_req && !credit_overflow) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Response path runs independently of the request path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_RN; i++) tx_data[i] <= '0;
            v_tx_data   <= '0;
            pre_rx_data <= 1'b0;
            err         <= 1'b0;
        end else begin
            v_tx_data   <= '0;
            pre_rx_data <= v_rx_data;
            for (int i = 0; i < N_RN; i++) begin
                if (v_rx_data && rx_data.dst == NODE_ID_W'(i)) begin
                    tx_data[i]   <= rx_data;
                    v_tx_data[i] <= 1'b1;
                end
            end
            if (push_overflow || credit_overflow || bad_dst) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_mux.sv
// tb/tb_noc_mux.sv - self-checking bench for noc_mux against a queue-based reference model
module tb_noc_mux;
    import node_package::*;

    localparam int N_RN       = 4;
    localparam int DEPTH      = 4;
    localparam int SN_CREDITS = 2;

    logic            clk = 1'b0;
    logic            reset;
    ReqType          rx_req [N_RN];
    logic [N_RN-1:0] v_rx_req;
    logic [N_RN-1:0] pre_rx_req;
    ReqType          tx_req;
    logic            v_tx_req;
    logic            pre_tx_req;
    DataType         rx_data;
    logic            v_rx_data;
    logic            pre_rx_data;
    DataType         tx_data [N_RN];
    logic [N_RN-1:0] v_tx_data;
    logic            err;

    noc_mux #(
        .N_RN(N_RN),
        .DEPTH(DEPTH),
        .SN_CREDITS(SN_CREDITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_req      (rx_req),
        .v_rx_req    (v_rx_req),
        .pre_rx_req  (pre_rx_req),
        .tx_req      (tx_req),
        .v_tx_req    (v_tx_req),
        .pre_tx_req  (pre_tx_req),
        .rx_data     (rx_data),
        .v_rx_data   (v_rx_data),
        .pre_rx_data (pre_rx_data),
        .tx_data     (tx_data),
        .v_tx_data   (v_tx_data),
        .err         (err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain queues per port, a credit integer, a round-robin start index
    ReqType          mq [N_RN][$];
    int              m_cnt;
    int              m_rr;
    logic            m_err;
    ReqType          m_tx_req;
    logic            m_v_tx_req;
    logic [N_RN-1:0] m_pre_rx_req;
    DataType         m_tx_data [N_RN];
    logic [N_RN-1:0] m_v_tx_data;
    logic            m_pre_rx_data;
    int              gnt_log [$];

    task automatic model_reset();
        for (int i = 0; i < N_RN; i++) begin
            mq[i].delete();
            m_tx_data[i] = '0;
        end
        m_cnt = SN_CREDITS;
        m_rr = 0;
        m_err = 1'b0;
        m_tx_req = '0;
        m_v_tx_req = 1'b0;
        m_pre_rx_req = '0;
        m_v_tx_data = '0;
        m_pre_rx_data = 1'b0;
    endtask

    task automatic model_step();
        int g;
        int d;
        bit full_pre [N_RN];
        g = -1;
        for (int i = 0; i < N_RN; i++) full_pre[i] = (mq[i].size() >= DEPTH);
        if (m_cnt > 0) begin
            for (int k = 0; k < N_RN; k++) begin
                if (g < 0 && mq[(m_rr + k) % N_RN].size() > 0) g = (m_rr + k) % N_RN;
            end
        end
        m_v_tx_req = 1'b0;
        m_pre_rx_req = '0;
        if (g >= 0) begin
            m_tx_req = mq[g].pop_front();
            m_tx_req.src = NODE_ID_W'(g);
            m_v_tx_req = 1'b1;
            m_pre_rx_req[g] = 1'b1;
            m_rr = (g + 1) % N_RN;
        end
        for (int i = 0; i < N_RN; i++) begin
            if (v_rx_req[i]) begin
                if (full_pre[i]) m_err = 1'b1;
                else mq[i].push_back(rx_req[i]);
            end
        end
        if (pre_tx_req && g < 0 && m_cnt == SN_CREDITS) m_err = 1'b1;
        else m_cnt = m_cnt - ((g >= 0) ? 1 : 0) + (pre_tx_req ? 1 : 0);
        m_v_tx_data = '0;
        m_pre_rx_data = v_rx_data;
        if (v_rx_data) begin
            d = int'(rx_data.dst);
            if (d < N_RN) begin
                m_tx_data[d] = rx_data;
                m_v_tx_data[d] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("v_tx_req", v_tx_req, m_v_tx_req);
        check("tx_req", tx_req, m_tx_req);
        check("pre_rx_req", pre_rx_req, m_pre_rx_req);
        check("v_tx_data", v_tx_data, m_v_tx_data);
        for (int i = 0; i < N_RN; i++) check($sformatf("tx_data%0d", i), tx_data[i], m_tx_data[i]);
        check("pre_rx_data", pre_rx_data, m_pre_rx_data);
        check("err", err, m_err);
        check("cnt", dut.cnt, m_cnt);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N_RN; i++) rx_req[i] = '0;
        v_rx_req = '0;
        pre_tx_req = 1'b0;
        rx_data = '0;
        v_rx_data = 1'b0;
    endtask

    // Inputs are set at a falling edge; the model advances, then the DUT is sampled 1ns after the rising edge
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
        if (v_tx_req) gnt_log.push_back(int'(tx_req.src));
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        gnt_log.delete();
    endtask

    task automatic set_req(input int port, input logic [15:0] addr);
        rx_req[port].src  = NODE_ID_W'($urandom);
        rx_req[port].addr = addr;
        rx_req[port].op   = OP_W'($urandom);
        v_rx_req[port]    = 1'b1;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Single request on port 2
        set_req(2, 16'h0010);
        step();
        step();
        check("r026_gnt_count", gnt_log.size(), 1);
        check("r026_src", (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);
        check("r026_addr", tx_req.addr, 16'h0010);
        check("r026_cnt", dut.cnt, 1);

        // Two requests per port, SN credit returned every cycle once grants start
        do_reset();
        for (int p = 0; p < N_RN; p++) set_req(p, 16'($urandom));
        step();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) for (int p = 0; p < N_RN; p++) set_req(p, 16'($urandom));
            pre_tx_req = 1'b1;
            step();
        end
        check("r027_gnt_count", gnt_log.size(), 8);
        for (int n = 0; n < 8; n++) check($sformatf("r027_order%0d", n), (gnt_log.size() > n) ? gnt_log[n] : -1, n % N_RN);
        step();

        // No credit returns: only SN_CREDITS issues, then one more per returned credit
        do_reset();
        for (int p = 0; p < N_RN; p++) set_req(p, 16'($urandom));
        step();
        set_req(0, 16'($urandom));
        step();
        for (int c = 0; c < 6; c++) step();
        check("r028_issues", gnt_log.size(), SN_CREDITS);
        pre_tx_req = 1'b1;
        step();
        for (int c = 0; c < 5; c++) step();
        check("r028_issues_after_credit", gnt_log.size(), SN_CREDITS + 1);

        // Overflow one port while credits are exhausted, then drain in order
        do_reset();
        set_req(3, 16'($urandom));
        step();
        set_req(3, 16'($urandom));
        step();
        for (int c = 0; c < 3; c++) step();
        gnt_log.delete();
        for (int w = 0; w < DEPTH + 1; w++) begin
            set_req(1, 16'(16'h0100 + w));
            step();
        end
        check("r029_err", err, 1'b1);
        for (int c = 0; c < 4; c++) begin
            pre_tx_req = 1'b1;
            step();
        end
        for (int c = 0; c < 4; c++) step();
        check("r029_drained", gnt_log.size(), DEPTH);
        check("r029_last_addr", tx_req.addr, 16'h0103);

        // Response routing and bad destination
        do_reset();
        rx_data.dst = 3'd3;
        rx_data.payload = $urandom;
        v_rx_data = 1'b1;
        step();
        check("r030_v_tx_data", v_tx_data, 4'b1000);
        check("r030_pre_rx_data", pre_rx_data, 1'b1);
        check("r030_err_clean", err, 1'b0);
        rx_data.dst = 3'd7;
        rx_data.payload = $urandom;
        v_rx_data = 1'b1;
        step();
        check("r030_drop_v", v_tx_data, 4'b0000);
        check("r030_drop_err", err, 1'b1);

        // Reset with queued entries discards them silently
        do_reset();
        for (int p = 0; p < 3; p++) set_req(p, 16'($urandom));
        step();
        do_reset();
        for (int c = 0; c < 4; c++) step();
        check("r031_no_issue", gnt_log.size(), 0);
        check("r031_cnt", dut.cnt, SN_CREDITS);

        // Randomized traffic on both paths
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N_RN; p++) begin
                if ($urandom_range(0, 9) < 3) set_req(p, 16'($urandom));
            end
            pre_tx_req = (m_cnt < SN_CREDITS) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 4) begin
                rx_data.dst = NODE_ID_W'($urandom_range(0, 5));
                rx_data.payload = $urandom;
                v_rx_data = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
